// File: rtl/cfg_prog_altera_ufm_pkg.sv
// Shared definitions for the UFM config-word engines: CSR offsets, CTRL bit layout,
// programming-engine state encodings and the CTRL status read helper.
package cfg_prog_altera_ufm_pkg;

   localparam logic [1:0] R_UFM_DATA_HI = 2'd0;
   localparam logic [1:0] R_UFM_DATA_LO = 2'd1;
   localparam logic [1:0] R_UFM_CTRL    = 2'd2;

   localparam int CTRL_PROG   = 0;
   localparam int CTRL_ERASE  = 1;
   localparam int CTRL_BUSY   = 5;
   localparam int CTRL_ERR    = 6;
   localparam int CTRL_ACTIVE = 7;

   // Longest erase/program request held while waiting for the UFM to raise busy.
   localparam int PULSE_MAX = 255;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PRE_WAIT,
      S_ADDR,
      S_ERASE,
      S_E_WAIT,
      S_DSHIFT,
      S_PROG,
      S_P_WAIT,
      S_FIN,
      S_ERR
   } ufm_state_t;

   function automatic logic [7:0] ctrl_status(input logic active, input logic err,
                                              input logic busy);
      logic [7:0] v;
      v = 8'h00;
      v[CTRL_ACTIVE] = active;
      v[CTRL_ERR]    = err;
      v[CTRL_BUSY]   = busy;
      return v;
   endfunction

endpackage

// File: rtl/cfg_prog_altera_ufm_if.sv
// CSR bus between configuration software (master) and the UFM programming engine (slave).
interface cfg_prog_altera_ufm_if;
   logic [4:0] csr_a;
   logic [7:0] csr_di;
   logic       csr_we;
   logic [7:0] csr_do;

   modport master (output csr_a, output csr_di, output csr_we, input csr_do);
   modport slave  (input csr_a, input csr_di, input csr_we, output csr_do);
endinterface

// File: rtl/cfg_prog_altera_ufm_serial_shifter.sv
// Generic N-bit MSB-first serialiser: two clocks per bit, data driven with sclk low,
// then sclk high; done pulses for one cycle after the last bit's high phase.
module ufm_serial_shifter #(
   parameter int N = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         start,
   input  logic [N-1:0] din,
   output logic         sdat,
   output logic         sclk,
   output logic         done
);

   localparam int CNT_W = $clog2(N);

   logic [N-1:0]     sreg;
   logic [CNT_W-1:0] bit_cnt;
   logic             running;
   logic             phase;

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg    <= '0;
         bit_cnt <= '0;
         running <= 1'b0;
         phase   <= 1'b0;
         sdat    <= 1'b0;
         sclk    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            sreg <= din;
         end
         if (start) begin
            running <= 1'b1;
            phase   <= 1'b0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
         end else if (running) begin
            if (!phase) begin
               sdat  <= sreg[N-1];
               sclk  <= 1'b0;
               phase <= 1'b1;
            end else begin
               sclk  <= 1'b1;
               phase <= 1'b0;
               sreg  <= {sreg[N-2:0], 1'b0};
               if (bit_cnt == CNT_W'(N - 1)) begin
                  running <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
         end else begin
            sclk <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cfg_prog_altera_ufm.sv
// Write-side engine for the 16-bit UFM config word: erase and/or program on CSR command.
// The UFM program request pin is named prog because program is a reserved word.
module cfg_prog_altera_ufm
   import cfg_prog_altera_ufm_pkg::*;
#(
   parameter logic [4:0] BASE_ADDR = 5'h4,
   parameter logic [8:0] UFM_ADDR  = 9'h000,
   parameter int         TIMEOUT_W = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   cfg_prog_altera_ufm_if.slave  csr,
   input  logic                  ufm_busy,
   output logic                  arclk,
   output logic                  ardin,
   output logic                  arshft,
   output logic                  drclk,
   output logic                  drdin,
   output logic                  drshft,
   output logic                  erase,
   output logic                  prog,
   output logic                  active,
   output logic                  reload
);

   localparam logic [4:0] A_HI   = BASE_ADDR + 5'(R_UFM_DATA_HI);
   localparam logic [4:0] A_LO   = BASE_ADDR + 5'(R_UFM_DATA_LO);
   localparam logic [4:0] A_CTRL = BASE_ADDR + 5'(R_UFM_CTRL);

   ufm_state_t           state;
   logic [15:0]          data_q;
   logic                 err;
   logic                 erase_flag;
   logic                 prog_flag;
   logic [TIMEOUT_W-1:0] cnt;
   logic                 busy_m;
   logic                 busy_s;
   logic                 a_start;
   logic                 d_start;
   logic                 a_done;
   logic                 d_done;
   logic                 accept;
   logic                 wait_expired;
   logic                 pulse_expired;

   assign accept = csr.csr_we && (csr.csr_a == A_CTRL) && (|csr.csr_di[1:0])
                   && !active && !reload && (state == S_IDLE);
   assign wait_expired  = &cnt;
   assign pulse_expired = (cnt == TIMEOUT_W'(PULSE_MAX));

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_m <= 1'b0;
         busy_s <= 1'b0;
      end else begin
         busy_m <= ufm_busy;
         busy_s <= busy_m;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= 16'hffff;
      end else if (csr.csr_we && !active) begin
         if (csr.csr_a == A_HI) data_q[15:8] <= csr.csr_di;
         if (csr.csr_a == A_LO) data_q[7:0]  <= csr.csr_di;
      end
   end

   always_comb begin
      csr.csr_do = 8'h00;
      if (csr.csr_a == A_HI)   csr.csr_do = data_q[15:8];
      if (csr.csr_a == A_LO)   csr.csr_do = data_q[7:0];
      if (csr.csr_a == A_CTRL) csr.csr_do = ctrl_status(active, err, busy_s);
   end

   // Every wait/pulse state is entered with cnt cleared, so one counter serves all timeouts.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         arshft     <= 1'b1;
         drshft     <= 1'b1;
         erase      <= 1'b0;
         prog       <= 1'b0;
         active     <= 1'b0;
         reload     <= 1'b0;
         err        <= 1'b0;
         erase_flag <= 1'b0;
         prog_flag  <= 1'b0;
         cnt        <= '0;
         a_start    <= 1'b0;
         d_start    <= 1'b0;
      end else begin
         a_start <= 1'b0;
         d_start <= 1'b0;
         reload  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  err        <= 1'b0;
                  erase_flag <= csr.csr_di[CTRL_ERASE];
                  prog_flag  <= csr.csr_di[CTRL_PROG];
                  active     <= 1'b1;
                  cnt        <= '0;
                  state      <= S_PRE_WAIT;
               end
            end
            S_PRE_WAIT: begin
               if (!busy_s) begin
                  arshft  <= 1'b1;
                  a_start <= 1'b1;
                  state   <= S_ADDR;
               end else if (wait_expired) begin
                  state <= S_ERR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_ADDR: begin
               if (a_done) begin
                  arshft <= 1'b0;
                  cnt    <= '0;
                  if (erase_flag) begin
                     erase <= 1'b1;
                     state <= S_ERASE;
                  end else begin
                     drshft  <= 1'b1;
                     d_start <= 1'b1;
                     state   <= S_DSHIFT;
                  end
               end
            end
            S_ERASE: begin
               if (busy_s) begin
                  erase <= 1'b0;
                  cnt   <= '0;
                  state <= S_E_WAIT;
               end else if (pulse_expired) begin
                  erase <= 1'b0;
                  state <= S_ERR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_E_WAIT: begin
               if (!busy_s) begin
                  if (prog_flag) begin
                     drshft  <= 1'b1;
                     d_start <= 1'b1;
                     state   <= S_DSHIFT;
                  end else begin
                     state <= S_FIN;
                  end
               end else if (wait_expired) begin
                  state <= S_ERR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DSHIFT: begin
               if (d_done) begin
                  drshft <= 1'b0;
                  prog   <= 1'b1;
                  cnt    <= '0;
                  state  <= S_PROG;
               end
            end
            S_PROG: begin
               if (busy_s) begin
                  prog  <= 1'b0;
                  cnt   <= '0;
                  state <= S_P_WAIT;
               end else if (pulse_expired) begin
                  prog  <= 1'b0;
                  state <= S_ERR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_P_WAIT: begin
               if (!busy_s) begin
                  state <= S_FIN;
               end else if (wait_expired) begin
                  state <= S_ERR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_FIN: begin
               reload <= prog_flag;
               active <= 1'b0;
               arshft <= 1'b1;
               drshft <= 1'b1;
               state  <= S_IDLE;
            end
            S_ERR: begin
               err    <= 1'b1;
               erase  <= 1'b0;
               prog   <= 1'b0;
               arshft <= 1'b1;
               drshft <= 1'b1;
               active <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   ufm_serial_shifter #(.N(9)) u_addr_shift (
      .clk   (clk),
      .rst   (rst),
      .load  (a_start),
      .start (a_start),
      .din   (UFM_ADDR),
      .sdat  (ardin),
      .sclk  (arclk),
      .done  (a_done)
   );

   ufm_serial_shifter #(.N(16)) u_data_shift (
      .clk   (clk),
      .rst   (rst),
      .load  (d_start),
      .start (d_start),
      .din   (data_q),
      .sdat  (drdin),
      .sclk  (drclk),
      .done  (d_done)
   );

endmodule

// File: tb/tb_cfg_prog_altera_ufm.sv
// Directed bench for cfg_prog_altera_ufm with a simple UFM busy model and a pin monitor
// that reassembles the serial address/data streams and counts request pulses.
module tb_cfg_prog_altera_ufm;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ufm_busy;
   logic arclk, ardin, arshft, drclk, drdin, drshft, erase, prog, active, reload;
   logic busy_stuck = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   cfg_prog_altera_ufm_if bus ();

   cfg_prog_altera_ufm #(
      .BASE_ADDR (5'h4),
      .UFM_ADDR  (9'h000),
      .TIMEOUT_W (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .csr      (bus.slave),
      .ufm_busy (ufm_busy),
      .arclk    (arclk),
      .ardin    (ardin),
      .arshft   (arshft),
      .drclk    (drclk),
      .drdin    (drdin),
      .drshft   (drshft),
      .erase    (erase),
      .prog     (prog),
      .active   (active),
      .reload   (reload)
   );

   always #5 clk = ~clk;

   // UFM model: each new erase/program request keeps busy high for 10 clocks.
   int   bcnt  = 0;
   logic req_q = 1'b0;
   always @(posedge clk) begin
      req_q <= erase | prog;
      if ((erase | prog) && !req_q) bcnt <= 10;
      else if (bcnt != 0) bcnt <= bcnt - 1;
   end
   assign ufm_busy = busy_stuck || (bcnt != 0);

   int          addr_cnt = 0, data_cnt = 0, erase_cnt = 0, prog_cnt = 0;
   int          reload_cnt = 0, overlap_cnt = 0;
   logic [8:0]  addr_bits = '0;
   logic [15:0] data_bits = '0;
   logic        arclk_q = 1'b0, drclk_q = 1'b0, erase_q = 1'b0, prog_q = 1'b0;

   always @(negedge clk) begin
      if (arclk && !arclk_q) begin
         addr_bits = {addr_bits[7:0], ardin};
         addr_cnt++;
      end
      if (drclk && !drclk_q) begin
         data_bits = {data_bits[14:0], drdin};
         data_cnt++;
      end
      if (erase && !erase_q) erase_cnt++;
      if (prog && !prog_q) prog_cnt++;
      if (reload) reload_cnt++;
      if (reload && active) overlap_cnt++;
      arclk_q = arclk;
      drclk_q = drclk;
      erase_q = erase;
      prog_q  = prog;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] a, input logic [7:0] d);
      bus.csr_a  = a;
      bus.csr_di = d;
      bus.csr_we = 1'b1;
      tick();
      bus.csr_we = 1'b0;
   endtask

   task automatic csr_read(input logic [4:0] a, output logic [7:0] d);
      bus.csr_a = a;
      #1;
      d = bus.csr_do;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input int max, output int cycles);
      cycles = 0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (!active) break;
         cycles++;
      end
      checkOutput("idle_bound", {31'd0, active}, 32'd0);
   endtask

   logic [7:0] rd;
   int         cyc;
   int         b_addr, b_data, b_erase, b_prog, b_reload;

   task automatic snap();
      b_addr   = addr_cnt;
      b_data   = data_cnt;
      b_erase  = erase_cnt;
      b_prog   = prog_cnt;
      b_reload = reload_cnt;
   endtask

   initial begin
      bus.csr_a  = '0;
      bus.csr_di = '0;
      bus.csr_we = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      csr_read(5'h4, rd); checkOutput("rst_data_hi", rd, 8'hff);
      csr_read(5'h5, rd); checkOutput("rst_data_lo", rd, 8'hff);
      csr_read(5'h6, rd); checkOutput("rst_ctrl", rd, 8'h00);
      csr_read(5'h0, rd); checkOutput("unmapped", rd, 8'h00);
      checkOutput("rst_pins", {arclk, ardin, arshft, drclk, drdin, drshft, erase, prog, active, reload},
                  10'b0010010000);

      // Erase + program of 16'hA55A
      applyStimulus(5'h4, 8'hA5);
      applyStimulus(5'h5, 8'h5A);
      csr_read(5'h4, rd); checkOutput("wr_data_hi", rd, 8'hA5);
      csr_read(5'h5, rd); checkOutput("wr_data_lo", rd, 8'h5A);
      snap();
      applyStimulus(5'h6, 8'h03);
      checkOutput("ep_active", {31'd0, active}, 32'd1);
      wait_idle(2000, cyc);
      repeat (3) tick();
      checkOutput("ep_addr_cnt", addr_cnt - b_addr, 9);
      checkOutput("ep_addr_bits", addr_bits, 9'h000);
      checkOutput("ep_erase", erase_cnt - b_erase, 1);
      checkOutput("ep_data_cnt", data_cnt - b_data, 16);
      checkOutput("ep_data_bits", data_bits, 16'hA55A);
      checkOutput("ep_prog", prog_cnt - b_prog, 1);
      checkOutput("ep_reload", reload_cnt - b_reload, 1);
      csr_read(5'h6, rd); checkOutput("ep_ctrl", rd, 8'h00);
      checkOutput("ep_shft", {30'd0, arshft, drshft}, 2'b11);

      // Erase only
      snap();
      applyStimulus(5'h6, 8'h02);
      wait_idle(2000, cyc);
      repeat (3) tick();
      checkOutput("e_erase", erase_cnt - b_erase, 1);
      checkOutput("e_addr_cnt", addr_cnt - b_addr, 9);
      checkOutput("e_data_cnt", data_cnt - b_data, 0);
      checkOutput("e_prog", prog_cnt - b_prog, 0);
      checkOutput("e_reload", reload_cnt - b_reload, 0);

      // Busy stuck high: PRE_WAIT times out after 2^8-1 counts
      busy_stuck = 1'b1;
      repeat (4) tick();
      snap();
      applyStimulus(5'h6, 8'h03);
      wait_idle(1000, cyc);
      checkOutput("to_cycles_in_range", {31'd0, (cyc >= 250 && cyc <= 260)}, 32'd1);
      csr_read(5'h6, rd); checkOutput("to_ctrl", rd, 8'h60);
      repeat (2) tick();
      checkOutput("to_reload", reload_cnt - b_reload, 0);
      checkOutput("to_addr_cnt", addr_cnt - b_addr, 0);
      checkOutput("to_pins", {29'd0, arshft, drshft, erase | prog}, 3'b110);
      busy_stuck = 1'b0;
      repeat (4) tick();
      csr_read(5'h6, rd); checkOutput("to_ctrl_sticky", rd, 8'h40);

      // Writes while active are ignored
      snap();
      applyStimulus(5'h6, 8'h01);
      applyStimulus(5'h4, 8'h00);
      applyStimulus(5'h6, 8'h01);
      wait_idle(2000, cyc);
      repeat (30) tick();
      csr_read(5'h4, rd); checkOutput("prot_data_hi", rd, 8'hA5);
      checkOutput("prot_prog", prog_cnt - b_prog, 1);
      checkOutput("prot_reload", reload_cnt - b_reload, 1);
      checkOutput("prot_data_bits", data_bits, 16'hA55A);
      csr_read(5'h6, rd); checkOutput("prot_err_clr", rd, 8'h00);

      // Reset in the middle of the data shift, then a clean command
      snap();
      applyStimulus(5'h6, 8'h01);
      for (int i = 0; i < 500; i++) begin
         if (data_cnt - b_data >= 7) break;
         tick();
      end
      checkOutput("mid_reached_bit7", data_cnt - b_data, 7);
      rst = 1'b1;
      tick();
      checkOutput("mid_rst_pins", {28'd0, drshft, prog, active, drclk}, 4'b1000);
      csr_read(5'h4, rd); checkOutput("mid_rst_data", rd, 8'hff);
      rst = 1'b0;
      tick();
      applyStimulus(5'h4, 8'h3C);
      applyStimulus(5'h5, 8'hC3);
      snap();
      applyStimulus(5'h6, 8'h01);
      wait_idle(2000, cyc);
      repeat (3) tick();
      checkOutput("post_data_cnt", data_cnt - b_data, 16);
      checkOutput("post_data_bits", data_bits, 16'h3CC3);
      checkOutput("post_reload", reload_cnt - b_reload, 1);
      csr_read(5'h6, rd); checkOutput("post_ctrl", rd, 8'h00);

      checkOutput("reload_active_overlap", overlap_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
